// File: rtl/rns_mrc_sign_pipe.sv
// Pipelined RNS normaliser front end. An NDIG-digit residue word is converted to
// mixed-radix (MR) digits by one conversion stage per digit, and the output
// register derives the sign, zero, half-range (NaN) and digit-error flags.
//
// Ports:
//   clk, aclr_n            clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake (in_ready is combinational from out_ready)
//   in_res                 residues, digit k at [k*W +: W]
//   in_signed              1 = signed interpretation, travels with the word
//   out_valid/out_ready    output handshake
//   out_mr                 MR digits a0..a(NDIG-1), a0 at LSBs
//   out_sign/zero/half/err result flags
module rns_mrc_sign_pipe #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned W    = 18,
  parameter logic [NDIG*W-1:0] MODS = {18'd131072, 18'd241, 18'd251, 18'd257,
                                       18'd8191, 18'd65521, 18'd65537, 18'd131071}
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NDIG*W-1:0] in_res,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NDIG*W-1:0] out_mr,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_half,
  output logic              out_err
);

  localparam int unsigned DW = W + 1;
  localparam int unsigned PW = 2 * W + 1;

  // Modulus of digit k.
  function automatic logic [W-1:0] mod_at(input int unsigned k);
    return MODS[k*W +: W];
  endfunction

  function automatic longint gcd_of(input longint a, input longint b);
    longint t;
    while (b != 64'sd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Multiplicative inverse of a modulo m (extended Euclid).
  function automatic longint mod_inv(input longint a, input longint m);
    longint t;
    longint new_t;
    longint r;
    longint new_r;
    longint q;
    longint tmp;
    t     = 64'sd0;
    new_t = 64'sd1;
    r     = m;
    new_r = a % m;
    while (new_r != 64'sd0) begin
      q     = r / new_r;
      tmp   = t - q * new_t;
      t     = new_t;
      new_t = tmp;
      tmp   = r - q * new_r;
      r     = new_r;
      new_r = tmp;
    end
    if (t < 64'sd0) t = t + m;
    return t;
  endfunction

  localparam logic [W-1:0] MTOP = mod_at(NDIG - 1);
  localparam logic [W-1:0] HALF = MTOP >> 1;

  // Elaboration-time parameter sanity. Moduli are W-bit fields, so < 2^W holds by construction.
  if (NDIG < 2) begin : g_bad_ndig
    $error("rns_mrc_sign_pipe: NDIG must be >= 2");
  end
  if (MTOP[0]) begin : g_bad_top
    $error("rns_mrc_sign_pipe: top modulus must be even");
  end
  for (genvar k = 0; k < NDIG; k++) begin : g_chk
    localparam logic [W-1:0] MK = mod_at(k);
    if (MK < W'(2)) begin : g_bad_small
      $error("rns_mrc_sign_pipe: modulus below 2");
    end
    for (genvar j = 0; j < k; j++) begin : g_pair
      if (gcd_of(longint'(MK), longint'(mod_at(j))) != 64'sd1) begin : g_bad_gcd
        $error("rns_mrc_sign_pipe: moduli not pairwise coprime");
      end
    end
  end

  // stg[0] is the input register; stg[s] holds the word after conversion stage s-1.
  logic [W-1:0]    stg [NDIG][NDIG];
  logic [W-1:0]    nxt [NDIG][NDIG];
  logic [NDIG-1:0] vld;
  logic [NDIG-1:0] err;
  logic [NDIG-1:0] sgn;
  logic [NDIG-1:0] over;
  logic            advance;

  // Whole pipeline moves in lock-step; bubbles are kept.
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // Input residues and per-digit range check.
  for (genvar j = 0; j < NDIG; j++) begin : g_in
    localparam logic [W-1:0] MJ = mod_at(j);
    assign nxt[0][j] = in_res[j*W +: W];
    assign over[j]   = (in_res[j*W +: W] >= MJ);
  end

  // Conversion stage K = s-1: a_K is fixed, every higher digit becomes (r_j - a_K) * inv(m_K) mod m_j.
  for (genvar s = 1; s < NDIG; s++) begin : g_stage
    localparam int unsigned  K  = s - 1;
    localparam logic [W-1:0] MK = mod_at(K);
    for (genvar j = 0; j < NDIG; j++) begin : g_dig
      if (j <= K) begin : g_keep
        assign nxt[s][j] = stg[s-1][j];
      end else begin : g_red
        localparam logic [W-1:0] MJ  = mod_at(j);
        localparam logic [W-1:0] INV = W'(mod_inv(longint'(MK) % longint'(MJ), longint'(MJ)));
        logic [W-1:0]  akr;
        logic [DW-1:0] diff;
        logic [PW-1:0] prod;
        // a_K is reduced mod m_j first so the wrapped subtraction can never underflow.
        always_comb begin
          akr = stg[s-1][K] % MJ;
          if (stg[s-1][j] >= akr) diff = DW'(stg[s-1][j]) - DW'(akr);
          else                    diff = DW'(stg[s-1][j]) + DW'(MJ) - DW'(akr);
          prod = PW'(diff) * PW'(INV);
        end
        assign nxt[s][j] = W'(prod % PW'(MJ));
      end
    end
  end

  // Flag terms from the fully converted word.
  logic [W-1:0] top;
  logic         lower_zero;
  logic         is_half;
  logic         top_neg;
  logic         err_top;
  logic         sgn_top;

  always_comb begin
    lower_zero = 1'b1;
    for (int j = 0; j < NDIG - 1; j++) begin
      if (stg[NDIG-1][j] != '0) lower_zero = 1'b0;
    end
  end

  assign top     = stg[NDIG-1][NDIG-1];
  assign is_half = lower_zero & (top == HALF);
  assign top_neg = (top >= HALF);
  assign err_top = err[NDIG-1];
  assign sgn_top = sgn[NDIG-1];

  // Pipeline and output registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int s = 0; s < NDIG; s++) begin
        for (int j = 0; j < NDIG; j++) stg[s][j] <= '0;
      end
      vld       <= '0;
      err       <= '0;
      sgn       <= '0;
      out_valid <= 1'b0;
      out_mr    <= '0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_half  <= 1'b0;
      out_err   <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < NDIG; s++) begin
        for (int j = 0; j < NDIG; j++) stg[s][j] <= nxt[s][j];
      end
      vld       <= {vld[NDIG-2:0], in_valid};
      err       <= {err[NDIG-2:0], |over};
      sgn       <= {sgn[NDIG-2:0], in_signed};
      out_valid <= vld[NDIG-1];
      for (int j = 0; j < NDIG; j++) out_mr[j*W +: W] <= stg[NDIG-1][j];
      out_err   <= err_top;
      out_zero  <= !err_top & lower_zero & (top == '0);
      out_half  <= !err_top & sgn_top & is_half;
      out_sign  <= !err_top & sgn_top & top_neg & !is_half;
    end
  end

endmodule

// File: tb/tb_rns_mrc_sign_pipe.sv
// Directed bench for rns_mrc_sign_pipe with NDIG=3, W=18, MODS={7,9,16} (M=1008).
module tb_rns_mrc_sign_pipe;

  localparam int unsigned NDIG = 3;
  localparam int unsigned W    = 18;
  localparam logic [NDIG*W-1:0] MODS = {18'd16, 18'd9, 18'd7};

  logic              clk;
  logic              aclr_n;
  logic              in_valid;
  logic              in_ready;
  logic [NDIG*W-1:0] in_res;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic [NDIG*W-1:0] out_mr;
  logic              out_sign;
  logic              out_zero;
  logic              out_half;
  logic              out_err;

  int checks = 0;
  int errors = 0;

  rns_mrc_sign_pipe #(.NDIG(NDIG), .W(W), .MODS(MODS)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mr    (out_mr),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_half  (out_half),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r0, input int r1, input int r2, input bit sg);
    in_res    = {W'(r2), W'(r1), W'(r0)};
    in_signed = sg;
  endtask

  // One isolated word: accept, confirm it is not early, then check result at the 4th edge.
  task automatic run_one(input string tag, input int r0, input int r1, input int r2, input bit sg,
                         input int e0, input int e1, input int e2,
                         input bit es, input bit ez, input bit eh, input bit ee);
    drive(r0, r1, r2, sg);
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (!ee) begin
      chk({tag, "_a0"}, 64'(out_mr[0 +: W]), 64'(e0));
      chk({tag, "_a1"}, 64'(out_mr[W +: W]), 64'(e1));
      chk({tag, "_a2"}, 64'(out_mr[2*W +: W]), 64'(e2));
    end
    chk({tag, "_sign"}, 64'(out_sign), 64'(es));
    chk({tag, "_zero"}, 64'(out_zero), 64'(ez));
    chk({tag, "_half"}, 64'(out_half), 64'(eh));
    chk({tag, "_err"},  64'(out_err),  64'(ee));
    tick();
  endtask

  int wr  [5][3];
  int ex  [5][3];
  bit exs [5];

  initial begin
    int nsent;
    int nrecv;
    int hold;
    bit held_once;
    logic [NDIG*W-1:0] snap;

    // Stream words: X = 10, 100, 700, 63, 1 (signed); MR digits hand-derived.
    wr[0] = '{3, 1, 10}; ex[0] = '{3, 1, 0};  exs[0] = 1'b0;
    wr[1] = '{2, 1, 4};  ex[1] = '{2, 5, 1};  exs[1] = 1'b0;
    wr[2] = '{0, 7, 12}; ex[2] = '{0, 1, 11}; exs[2] = 1'b1;
    wr[3] = '{0, 0, 15}; ex[3] = '{0, 0, 1};  exs[3] = 1'b0;
    wr[4] = '{1, 1, 1};  ex[4] = '{1, 0, 0};  exs[4] = 1'b0;

    aclr_n    = 1'b0;
    in_valid  = 1'b0;
    in_res    = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    snap      = '0;

    // Reset state
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mr",    64'(out_mr),    64'd0);
    chk("rst_flags", 64'({out_sign, out_zero, out_half, out_err}), 64'd0);
    @(negedge clk);
    aclr_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Single-word directed vectors
    run_one("t1",   5, 5, 5,  1'b1, 5, 0, 0,  1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t2s",  6, 8, 15, 1'b1, 6, 8, 15, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("t2u",  6, 8, 15, 1'b0, 6, 8, 15, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t3h",  0, 0, 8,  1'b1, 0, 0, 8,  1'b0, 1'b0, 1'b1, 1'b0);
    run_one("t3u",  0, 0, 8,  1'b0, 0, 0, 8,  1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t3b",  6, 8, 7,  1'b1, 6, 8, 7,  1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t4z",  0, 0, 0,  1'b1, 0, 0, 0,  1'b0, 1'b1, 1'b0, 1'b0);
    run_one("t4e",  7, 0, 0,  1'b1, 0, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1);
    run_one("t4e2", 0, 9, 8,  1'b1, 0, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back stream with a 3-cycle output stall
    nsent = 0;
    nrecv = 0;
    hold = 0;
    held_once = 1'b0;
    for (int c = 0; c < 40 && nrecv < 5; c++) begin
      if (out_valid && !held_once) begin
        hold = 3;
        held_once = 1'b1;
        snap = out_mr;
      end
      out_ready = (hold == 0);
      in_valid  = (nsent < 5);
      if (nsent < 5) drive(wr[nsent][0], wr[nsent][1], wr[nsent][2], 1'b1);
      #1;
      if (hold > 0) begin
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_valid", 64'(out_valid), 64'd1);
        if (hold < 3) chk("hold_stable", 64'(out_mr), 64'(snap));
      end
      if (in_valid && in_ready) nsent++;
      if (out_valid && out_ready) begin
        chk("stream_a0",   64'(out_mr[0 +: W]),   64'(ex[nrecv][0]));
        chk("stream_a1",   64'(out_mr[W +: W]),   64'(ex[nrecv][1]));
        chk("stream_a2",   64'(out_mr[2*W +: W]), 64'(ex[nrecv][2]));
        chk("stream_sign", 64'(out_sign),         64'(exs[nrecv]));
        nrecv++;
      end else if (nrecv > 0 && hold == 0) begin
        chk("stream_gap", 64'(out_valid), 64'd1);
      end
      if (hold > 0) hold--;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(nrecv), 64'd5);
    chk("stream_held", 64'(held_once), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_nodup", 64'(out_valid), 64'd0);
      tick();
    end

    // Reset with words in flight
    for (int i = 0; i < 4; i++) begin
      drive(0, 7, 12, 1'b1);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    aclr_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_mr",    64'(out_mr),    64'd0);
    chk("mid_rst_sign",  64'(out_sign),  64'd0);
    @(posedge clk);
    @(negedge clk);
    aclr_n = 1'b1;
    #1;
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_stale", 64'(out_valid), 64'd0);
    end
    run_one("t6", 2, 1, 4, 1'b1, 2, 5, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rns_mrc_sign_pipe.md
Name: rns_mrc_sign_pipe

Overview:
- Parametrised residue-number-system (RNS) normaliser front end.
- Converts an NDIG-digit RNS word into mixed-radix (MR) digits through a fully pipelined mixed-radix conversion.
- Derives sign, zero, half-range (NaN) and digit-error flags from the MR digits.
- Generalises the fixed 8x18 normaliser with valid/ready backpressure, a signed/unsigned mode and per-digit range checking.

Parameters:
NDIG, 8, number of residue digits (>=2)
W, 18, bits per digit
MODS, {8 x W-bit moduli, digit 0 at LSBs}, pairwise-coprime moduli; MODS[NDIG-1] must be even and every modulus must be < 2^W. Elaboration error otherwise.

Ports:
clk  in  1  clock
aclr_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
in_res  in  NDIG*W  residues, digit k at [k*W +: W]
in_signed  in  1  1 = signed interpretation; captured with the data
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_mr  out  NDIG*W  MR digits a0..a(NDIG-1), a0 at LSBs
out_sign  out  1  1 = negative (signed mode only)
out_zero  out  1  value is zero
out_half  out  1  value equals M/2 (signed NaN)
out_err  out  1  at least one input residue >= its modulus

Behaviour:
- Reset (aclr_n=0, asynchronous): all stage valid bits, out_valid, out_mr, out_sign, out_zero, out_half and out_err clear to 0; in_ready=1 once reset is released.
- Definitions:
  - M = product of MODS.
  - X = a0 + a1*m0 + a2*m0*m1 + ...
  - 0 <= ak < mk.
- Pipeline:
  - Input register, then NDIG-1 conversion stages, then the output/flag register.
  - Latency is NDIG+1 clk from the accepting edge to out_valid with no stall (4 for NDIG=3).
- Conversion stage k (k = 0..NDIG-2):
  - Emits ak = rk.
  - For every j > k: rj <= ((rj - ak) mod mj) * inv(mk mod mj) mod mj.
  - Subtraction wraps modulo mj (add mj when rj < ak); it never goes negative.
  - Inverses are elaboration-time constants computed from MODS.
  - The last digit a(NDIG-1) = r(NDIG-1) after stage NDIG-2.
  - Earlier MR digits are carried forward unchanged.
- Error:
  - out_err = OR over k of (in_res[k] >= mk), evaluated at the input register and carried along the pipeline.
  - When out_err=1, out_mr contents are don't-care, and out_sign, out_zero and out_half are forced to 0.
- Flags (output register):
  - out_zero = all ak == 0.
  - out_half = in_signed & (a(NDIG-1) == m(NDIG-1)/2) & all lower ak == 0.
  - out_sign = in_signed & (a(NDIG-1) >= m(NDIG-1)/2) & !out_half. This is exact because the top modulus is even.
  - In unsigned mode out_sign = out_half = 0.
- Handshake:
  - Global advance = !out_valid | out_ready.
  - in_ready = advance, and is combinational from out_ready.
  - All stages shift together when advance=1 and hold when advance=0.
  - Bubbles are not squeezed.
  - A word is accepted when in_valid & in_ready at a rising clk edge.
  - out_* stay stable while out_valid & !out_ready.
- Throughput is 1 word/clk when out_ready is held high.
- Reset mid-operation discards all in-flight words; no partial output is emitted after release.
- Arithmetic widths:
  - Intermediate products need up to 2W bits before reduction.
  - Each stage registers only W-bit reduced digits.

Test Plan:
Use NDIG=3, W=18, MODS={7,9,16}, so M=1008. Inverses are 4 (7 mod 9), 7 (7 mod 16) and 9 (9 mod 16).
1. in_res=(5,5,5), signed, out_ready=1 -> after 4 clk: out_mr=(5,0,0), sign=0, zero=0, half=0, err=0.
2. in_res=(6,8,15) (X=1007=-1), signed -> out_mr=(6,8,15), sign=1. The same input unsigned -> sign=0.
3. in_res=(0,0,8) (X=504), signed -> out_mr=(0,0,8), half=1, sign=0. Then in_res=(6,8,7) (X=503) -> out_mr=(6,8,7), sign=0, half=0.
4. in_res=(0,0,0) -> zero=1. in_res=(7,0,0) -> err=1 with sign/zero/half=0.
5. Stream 5 back-to-back words:
   - Hold out_ready=0 for 3 clk once out_valid rises.
   - Required: in_ready=0 during the hold, out_* stable, and no word lost or duplicated.
   - Results emerge in order, 1/clk after release.
6. Assert aclr_n=0 for 1 clk with 3 words in flight -> out_valid=0 immediately. After release no stale words appear, and a new word returns correctly 4 clk after acceptance.
